// File: rtl/hash_stream_pkg.sv
// Shared types and constants for the hash-table stream master.
// Response flag positions match the hash-table stream slave's 64-bit response word.
package hash_stream_pkg;

   localparam int unsigned RESP_WIDTH = 64;
   localparam int unsigned OP_WIDTH   = 2;
   localparam int unsigned STAT_WIDTH = 3;

   localparam int unsigned FLAG_NO_DEL_TARGET = 60;
   localparam int unsigned FLAG_NO_SPACE      = 61;
   localparam int unsigned FLAG_NOT_FOUND     = 62;
   localparam int unsigned FLAG_KEY_PRESENT   = 63;

   typedef enum logic [OP_WIDTH-1:0] {
      OpNop    = 2'b00,
      OpRead   = 2'b01,
      OpWrite  = 2'b10,
      OpDelete = 2'b11
   } op_e;

   typedef enum logic [STAT_WIDTH-1:0] {
      StatusOk          = 3'd0,
      StatusNotFound    = 3'd1,
      StatusNoSpace     = 3'd2,
      StatusNoDelTarget = 3'd3,
      StatusKeyPresent  = 3'd4,
      StatusMultiFlag   = 3'd7
   } status_e;

   // flags = {key_present, not_found, no_space, no_del_target}
   function automatic status_e decode_status(input logic [3:0] flags);
      status_e st;
      unique case (flags)
         4'b0000: st = StatusOk;
         4'b0100: st = StatusNotFound;
         4'b0010: st = StatusNoSpace;
         4'b0001: st = StatusNoDelTarget;
         4'b1000: st = StatusKeyPresent;
         default: st = StatusMultiFlag;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/hash_op_fifo.sv
// In-order FIFO of opcodes for requests that are awaiting a response.
// Pushes while full and pops while empty are ignored.
module hash_op_fifo
   import hash_stream_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = OP_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rptr_q];
   assign count   = count_q;

   always_comb begin
      mem_d = mem_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata;
      end
      // DEPTH is a power of two, so the pointers wrap naturally
      wptr_d  = wptr_q + AW'(do_push);
      rptr_d  = rptr_q + AW'(do_pop);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/hash_stream_master.sv
// AXI-stream initiator for the hash-table stream slave: issues single-beat requests
// and pairs each response with the opcode of its request.
module hash_stream_master
   import hash_stream_pkg::*;
#(
   parameter int unsigned KEY_WIDTH       = 5,
   parameter int unsigned DATA_WIDTH      = 25,
   parameter int unsigned KEEP_WIDTH      = KEY_WIDTH + DATA_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [1:0]                           cmd_op,
   input  logic [KEY_WIDTH-1:0]                 cmd_key,
   input  logic [DATA_WIDTH-1:0]                cmd_data,
   output logic                                 req_valid,
   input  logic                                 req_ready,
   output logic                                 req_last,
   output logic [KEEP_WIDTH-1:0]                req_keep,
   output logic [2+KEY_WIDTH+DATA_WIDTH-1:0]    req_data,
   input  logic                                 rsp_in_valid,
   output logic                                 rsp_in_ready,
   input  logic                                 rsp_in_last,
   input  logic [RESP_WIDTH-1:0]                rsp_in_data,
   output logic                                 rsp_valid,
   input  logic                                 rsp_ready,
   output logic [1:0]                           rsp_op,
   output logic [2:0]                           rsp_status,
   output logic [DATA_WIDTH-1:0]                rsp_data,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
   output logic                                 proto_err
);

   localparam int unsigned REQ_W = 2 + KEY_WIDTH + DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic                  req_valid_q, req_valid_d;
   logic [REQ_W-1:0]      req_data_q, req_data_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [1:0]            rsp_op_q, rsp_op_d;
   logic [2:0]            rsp_status_q, rsp_status_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  proto_err_q, proto_err_d;

   logic [CNT_W-1:0]      fifo_count;
   logic [1:0]            fifo_rdata;
   logic                  fifo_full, fifo_empty, fifo_pop;
   logic                  room, cmd_fire, req_fire, rsp_in_fire, rsp_fire;
   logic [3:0]            flags;
   status_e               status;
   logic                  unused_rsp;

   // The beat still waiting in the output register needs a FIFO slot too
   assign room = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, req_valid_q})
                 < {1'b0, CNT_W'(MAX_OUTSTANDING)};

   assign cmd_ready    = reset & (~req_valid_q | req_ready) & room;
   assign rsp_in_ready = reset & (~rsp_valid_q | rsp_ready);

   assign cmd_fire    = cmd_valid & cmd_ready;
   assign req_fire    = req_valid_q & req_ready;
   assign rsp_in_fire = rsp_in_valid & rsp_in_ready;
   assign rsp_fire    = rsp_valid_q & rsp_ready;
   assign fifo_pop    = rsp_in_fire & ~fifo_empty;

   assign flags  = {rsp_in_data[FLAG_KEY_PRESENT], rsp_in_data[FLAG_NOT_FOUND],
                    rsp_in_data[FLAG_NO_SPACE], rsp_in_data[FLAG_NO_DEL_TARGET]};
   assign status = decode_status(flags);

   // tlast carries no information on single-beat packets
   assign unused_rsp = rsp_in_last ^ (^rsp_in_data) ^ fifo_full;

   hash_op_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (2)
   ) u_op_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_fire),
      .wdata (req_data_q[REQ_W-1 -: 2]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      req_valid_d = req_valid_q;
      req_data_d  = req_data_q;
      if (req_fire) begin
         req_valid_d = 1'b0;
      end
      if (cmd_fire && (cmd_op != OpNop)) begin
         req_valid_d = 1'b1;
         req_data_d  = {cmd_op, cmd_key, cmd_data};
      end
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_op_d     = rsp_op_q;
      rsp_status_d = rsp_status_q;
      rsp_data_d   = rsp_data_q;
      if (rsp_fire) begin
         rsp_valid_d = 1'b0;
      end
      if (fifo_pop) begin
         rsp_valid_d  = 1'b1;
         rsp_op_d     = fifo_rdata;
         rsp_status_d = status;
         rsp_data_d   = ((fifo_rdata == OpRead) && (status == StatusOk))
                        ? rsp_in_data[DATA_WIDTH-1:0] : '0;
      end
      // An orphan response is swallowed and only flagged
      proto_err_d = proto_err_q | (rsp_in_fire & fifo_empty);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_valid_q  <= 1'b0;
         req_data_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_op_q     <= '0;
         rsp_status_q <= '0;
         rsp_data_q   <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         req_valid_q  <= req_valid_d;
         req_data_q   <= req_data_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_op_q     <= rsp_op_d;
         rsp_status_q <= rsp_status_d;
         rsp_data_q   <= rsp_data_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign req_valid   = req_valid_q;
   assign req_data    = req_data_q;
   assign req_last    = 1'b1;
   assign req_keep    = '1;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_op      = rsp_op_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_data    = rsp_data_q;
   assign outstanding = fifo_count;
   assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_hash_stream_master.sv
// Bench for hash_stream_master: directed scenarios plus a randomized run in which
// the bench plays both host and hash table, checked against a queue-based model.
module tb_hash_stream_master;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [4:0]  cmd_key = '0;
   logic [24:0] cmd_data = '0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic        req_last;
   logic [29:0] req_keep;
   logic [31:0] req_data;
   logic        rsp_in_valid = 1'b0;
   logic        rsp_in_ready;
   logic        rsp_in_last = 1'b1;
   logic [63:0] rsp_in_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_op;
   logic [2:0]  rsp_status;
   logic [24:0] rsp_data;
   logic [2:0]  outstanding;
   logic        proto_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   hash_stream_master u_dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_key      (cmd_key),
      .cmd_data     (cmd_data),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_last     (req_last),
      .req_keep     (req_keep),
      .req_data     (req_data),
      .rsp_in_valid (rsp_in_valid),
      .rsp_in_ready (rsp_in_ready),
      .rsp_in_last  (rsp_in_last),
      .rsp_in_data  (rsp_in_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_op       (rsp_op),
      .rsp_status   (rsp_status),
      .rsp_data     (rsp_data),
      .outstanding  (outstanding),
      .proto_err    (proto_err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Status from the table's flag rules: f = {bit63, bit62, bit61, bit60}
   function automatic logic [2:0] ref_status(input logic [3:0] f);
      int n;
      n = $countones(f);
      if (n == 0) return 3'd0;
      if (n > 1) return 3'd7;
      if (f[2]) return 3'd1;
      if (f[1]) return 3'd2;
      if (f[0]) return 3'd3;
      return 3'd4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [4:0] key, input logic [24:0] data);
      bit ok;
      ok = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_key = key;
      cmd_data = data;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      check_eq("cmd_accept", ok, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic take_req(input logic [31:0] exp);
      bit ok;
      ok = 0;
      req_ready = 1'b1;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (req_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
      check_eq("req_seen", ok, 1);
      check_eq("req_data", req_data, exp);
      check_eq("req_last", req_last, 1);
      check_eq("req_keep", req_keep, 30'h3FFF_FFFF);
      tick();
      req_ready = 1'b0;
   endtask

   task automatic send_rsp(input logic [63:0] word);
      bit ok;
      ok = 0;
      rsp_in_valid = 1'b1;
      rsp_in_data = word;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (rsp_in_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      check_eq("rsp_in_accept", ok, 1);
      tick();
      rsp_in_valid = 1'b0;
   endtask

   task automatic get_rsp(input logic [1:0] op, input logic [2:0] st, input logic [24:0] data);
      bit ok;
      ok = 0;
      rsp_ready = 1'b1;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
      check_eq("rsp_seen", ok, 1);
      check_eq("rsp_op", rsp_op, op);
      check_eq("rsp_status", rsp_status, st);
      check_eq("rsp_data", rsp_data, data);
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      req_ready = 1'b0;
      rsp_in_valid = 1'b0;
      rsp_ready = 1'b0;
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
   endtask

   logic [31:0] exp_req_q[$];
   logic [63:0] tbl_q[$];
   logic [31:0] exp_rsp_q[$];
   int          model_out;
   bit          cf, rf, rif, rof;
   logic [63:0] word;
   logic [31:0] beat;
   logic [2:0]  st;
   logic [24:0] rd;
   int          acc;
   bit          fire;

   initial begin
      // Reset state
      #3;
      check_eq("rst_req_valid", req_valid, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_cmd_ready", cmd_ready, 0);
      check_eq("rst_rsp_in_ready", rsp_in_ready, 0);
      check_eq("rst_outstanding", outstanding, 0);
      check_eq("rst_proto_err", proto_err, 0);
      check_eq("rst_req_data", req_data, 0);
      tick();
      reset = 1'b1;
      tick();

      // Single WRITE
      send_cmd(2'b10, 5'd5, 25'h1ABCDEF);
      check_eq("wr_req_valid", req_valid, 1);
      take_req({2'b10, 5'd5, 25'h1ABCDEF});
      check_eq("wr_out1", outstanding, 1);
      send_rsp(64'h0);
      check_eq("wr_out0", outstanding, 0);
      get_rsp(2'b10, 3'd0, 25'd0);

      // READ hit and miss
      send_cmd(2'b01, 5'd5, 25'h0);
      take_req({2'b01, 5'd5, 25'h0});
      send_rsp(64'h0000_0000_01AB_CDEF);
      get_rsp(2'b01, 3'd0, 25'h1ABCDEF);
      send_cmd(2'b01, 5'd5, 25'h0);
      take_req({2'b01, 5'd5, 25'h0});
      send_rsp(64'h4000_0000_01AB_CDEF);
      get_rsp(2'b01, 3'd1, 25'd0);

      // Multiple flags
      send_cmd(2'b11, 5'd9, 25'h0);
      take_req({2'b11, 5'd9, 25'h0});
      send_rsp(64'hA000_0000_0000_0000);
      get_rsp(2'b11, 3'd7, 25'd0);

      // NOP is dropped
      send_cmd(2'b00, 5'd3, 25'h123);
      repeat (3) tick();
      check_eq("nop_no_beat", req_valid, 0);
      check_eq("nop_out", outstanding, 0);

      // Back-to-back commands fill the outstanding window
      req_ready = 1'b1;
      acc = 0;
      cmd_valid = 1'b1;
      cmd_op = 2'b10;
      cmd_key = 5'd0;
      cmd_data = 25'h55;
      #1;
      for (int i = 0; i < 40; i++) begin
         if (outstanding == 3'd4) break;
         fire = cmd_valid & cmd_ready;
         tick();
         if (fire) begin
            acc++;
            cmd_key = 5'(acc);
            if (acc == 6) cmd_valid = 1'b0;
         end
         #1;
      end
      check_eq("b2b_out4", outstanding, 4);
      check_eq("b2b_accepted", acc, 4);
      check_eq("b2b_cmd_ready0", cmd_ready, 0);
      req_ready = 1'b0;
      send_rsp(64'h0);
      #1;
      check_eq("b2b_out3", outstanding, 3);
      check_eq("b2b_cmd_ready1", cmd_ready, 1);
      cmd_valid = 1'b0;
      do_reset();

      // Orphan response
      send_rsp(64'h0);
      check_eq("orphan_rsp_valid", rsp_valid, 0);
      check_eq("orphan_proto_err", proto_err, 1);
      check_eq("orphan_out", outstanding, 0);
      repeat (5) tick();
      check_eq("orphan_sticky", proto_err, 1);
      do_reset();
      check_eq("orphan_cleared", proto_err, 0);

      // Randomized traffic against the queue model
      model_out = 0;
      cf = 0;
      rif = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!cmd_valid || cf) begin
            if (cyc < 2400 && $urandom_range(0, 1) == 1) begin
               cmd_valid = 1'b1;
               cmd_op = 2'($urandom);
               cmd_key = 5'($urandom);
               cmd_data = 25'($urandom);
            end else begin
               cmd_valid = 1'b0;
            end
         end
         req_ready = ($urandom_range(0, 3) != 0);
         rsp_ready = ($urandom_range(0, 2) != 0);
         if (!rsp_in_valid || rif) begin
            if (tbl_q.size() > 0 && $urandom_range(0, 1) == 1) begin
               rsp_in_valid = 1'b1;
               rsp_in_data = tbl_q[0];
            end else begin
               rsp_in_valid = 1'b0;
            end
         end
         #1;
         check_eq("rnd_outstanding", outstanding, model_out);
         cf = cmd_valid & cmd_ready;
         rf = req_valid & req_ready;
         rif = rsp_in_valid & rsp_in_ready;
         rof = rsp_valid & rsp_ready;
         if (cf && cmd_op != 2'b00) exp_req_q.push_back({cmd_op, cmd_key, cmd_data});
         if (rf) begin
            check_eq("rnd_req_expected", exp_req_q.size() != 0, 1);
            if (exp_req_q.size() != 0) begin
               beat = exp_req_q.pop_front();
               check_eq("rnd_req_data", req_data, beat);
               case ($urandom_range(0, 7))
                  0, 1, 2, 3: word = {4'b0000, 28'($urandom), 32'($urandom)};
                  4:          word = {4'(1 << $urandom_range(0, 3)), 28'($urandom), 32'($urandom)};
                  default:    word = {4'($urandom), 28'($urandom), 32'($urandom)};
               endcase
               st = ref_status(word[63:60]);
               rd = (beat[31:30] == 2'b01 && st == 3'd0) ? word[24:0] : 25'd0;
               tbl_q.push_back(word);
               exp_rsp_q.push_back({2'b00, beat[31:30], st, rd});
            end
         end
         if (rif && tbl_q.size() != 0) void'(tbl_q.pop_front());
         if (rof) begin
            check_eq("rnd_rsp_expected", exp_rsp_q.size() != 0, 1);
            if (exp_rsp_q.size() != 0) begin
               check_eq("rnd_rsp", {2'b00, rsp_op, rsp_status, rsp_data}, exp_rsp_q.pop_front());
            end
         end
         model_out = model_out + int'(rf) - int'(rif);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_in_valid = 1'b0;
      check_eq("rnd_req_drained", exp_req_q.size(), 0);
      check_eq("rnd_tbl_drained", tbl_q.size(), 0);
      check_eq("rnd_rsp_drained", exp_rsp_q.size(), 0);
      check_eq("rnd_out_final", outstanding, 0);
      check_eq("rnd_proto_err", proto_err, 0);
      do_reset();

      // Reset with traffic in flight
      for (int k = 1; k <= 3; k++) begin
         send_cmd(2'b10, 5'(k), 25'(k));
         take_req({2'b10, 5'(k), 25'(k)});
      end
      send_rsp(64'h8000_0000_0000_0000);
      check_eq("mid_out2", outstanding, 2);
      check_eq("mid_rsp_valid", rsp_valid, 1);
      check_eq("mid_rsp_status", rsp_status, 4);
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_out", outstanding, 0);
      check_eq("arst_rsp_valid", rsp_valid, 0);
      check_eq("arst_rsp_fields", {rsp_op, rsp_status, rsp_data}, 0);
      check_eq("arst_req_valid", req_valid, 0);
      check_eq("arst_req_data", req_data, 0);
      check_eq("arst_cmd_ready", cmd_ready, 0);
      check_eq("arst_rsp_in_ready", rsp_in_ready, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      send_cmd(2'b10, 5'd7, 25'h42);
      take_req({2'b10, 5'd7, 25'h42});
      check_eq("post_out1", outstanding, 1);
      send_rsp(64'h0);
      check_eq("post_out0", outstanding, 0);
      get_rsp(2'b10, 3'd0, 25'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
